// File: rtl/spw_pll_lock_supervisor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spw_pll_lock_supervisor: PLL reset sequencing, lock qualification and  |
// | core reset release. Optional loss counter: SPW_PLL_SUP_LOSS_CNT_EN.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module spw_pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4,
  parameter int CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state
`ifdef SPW_PLL_SUP_LOSS_CNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam int RET_W = $clog2(MAX_RETRIES + 2);
  localparam logic [CNT_W-1:0] C_PLL_TC    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STABLE_TC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] C_RET_MAX   = RET_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] retries_q, retries_d;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_q, pll_rst_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= PLL_RST;
      cnt_q      <= '0;
      retries_q  <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    if (force_relock) begin
      state_d   = PLL_RST;
      retries_d = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == C_PLL_TC) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = STABLE;
          end else if (cnt_q == C_LOCK_TC) begin
            if (retries_q == C_RET_MAX) begin
              state_d = FAIL;
            end else begin
              state_d   = PLL_RST;
              retries_d = retries_q + 1'b1;
            end
          end
        end
        STABLE: begin
          // Lock drop is tested first so it beats the terminal count.
          if (!locked_s_q) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == C_STABLE_TC) begin
            state_d   = RUN;
            retries_d = '0;
          end
        end
        RUN: begin
          if (!locked_s_q) state_d = WAIT_LOCK;
        end
        FAIL: state_d = FAIL;
        default: state_d = PLL_RST;
      endcase
    end

    // A relock request in PLL_RST keeps the state but must still restart the count.
    if (force_relock || (state_d != state_q)) cnt_d = '0;
    else                                      cnt_d = cnt_q + 1'b1;

    pll_rst_d  = 1'b1;
    core_rst_d = 1'b1;
    ready_d    = 1'b0;
    fail_d     = 1'b0;
    case (state_d)
      WAIT_LOCK, STABLE: pll_rst_d = 1'b0;
      RUN: begin
        pll_rst_d  = 1'b0;
        core_rst_d = 1'b0;
        ready_d    = 1'b1;
      end
      FAIL:    fail_d = 1'b1;
      default: pll_rst_d = 1'b1;
    endcase
  end

`ifdef SPW_PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (!force_relock && (state_q == RUN) && !locked_s_q && (loss_q != 8'hFF))
      loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) loss_q <= 8'd0;
    else     loss_q <= loss_d;
  end

  assign loss_count = loss_q;
`endif

  assign pll_rst  = pll_rst_q;
  assign core_rst = core_rst_q;
  assign ready    = ready_q;
  assign fail     = fail_q;
  assign state    = state_q;

endmodule
`default_nettype wire
